axi_lite_regfile_slave: RTL and testbench
=========================================

// Module: axi_lite_regfile_slave
// PURPOSE
//  AXI-Lite subordinate register file: the responder that the maestro/FSM write paths and the read port talk to.
//  Holds NUM_REGS 32-bit registers; serves bus writes (AW, W, B) and reads (AR, R) on independent channels.
//  Exposes register contents and per-register write pulses to control logic; a hardware-side update port is also provided.
// PARAMETERS
//  NUM_REGS   16            number of 32-bit registers (2..256)
//  BASE_ADDR  32'h0000_0000 byte address of register 0; register i sits at BASE_ADDR + 4*i
//  RESET_VAL  32'h0         reset value of every register
// PORTS
//  clk         in   1            single clock; all logic on posedge
//  rst_n       in   1            asynchronous, active-low reset
//  axi_slave   AXI_LITE.Slave -  aw_*, w_*, b_*, ar_*, r_* channels; 32-bit address and data
//  regs_o      out  NUM_REGS*32  register contents, reg i at [32*i +: 32]
//  wr_pulse_o  out  NUM_REGS     1-cycle pulse on bit i in the cycle reg i is updated by a bus write
//  hw_we_i     in   NUM_REGS     hardware write enable, per register
//  hw_data_i   in   NUM_REGS*32  hardware write data, same packing as regs_o
// BEHAVIOUR
//  Reset (rst_n=0, async): regs=RESET_VAL; b_valid=r_valid=0; b_resp=r_resp=2'b00; r_data=0; wr_pulse_o=0.
//   All capture flags are cleared. Any pending AW/W/AR is dropped and no B or R is issued for it.
//  Decode: off = addr - BASE_ADDR; idx = off[9:2]; addr[1:0] ignored.
//   Hit if addr >= BASE_ADDR and off < 4*NUM_REGS; otherwise miss.
//  Write path, states W_COLLECT / W_RESP:
//   W_COLLECT: aw_ready = !aw_have; w_ready = !w_have. AW and W are accepted in either order or in the same cycle.
//    Each handshake latches its payload and sets aw_have / w_have.
//   When aw_have && w_have at an edge, the commit happens at that edge:
//    hit: reg[idx] updated, wr_pulse_o[idx]=1 for 1 cycle, b_resp=OKAY 2'b00.
//    miss: no write, b_resp=SLVERR 2'b10.
//    In both cases b_valid<=1, flags cleared, go to W_RESP.
//   Latency: both handshakes at edge N gives the commit and b_valid high after edge N+1.
//   W_RESP: aw_ready=w_ready=0. b_valid and b_resp are held stable until b_ready; on b_valid&&b_ready go to W_COLLECT.
//  Read path, states R_IDLE / R_RESP:
//   R_IDLE: ar_ready=1. On handshake: r_data<=reg[idx] (hit, resp OKAY) or 32'h0 (miss, SLVERR); r_valid<=1; go to R_RESP.
//   R_RESP: ar_ready=0. r_data, r_resp and r_valid are held until r_ready, then return to R_IDLE.
//   There is no combinational path from valid to ready.
//  Simultaneous events:
//   AR to reg i in the same cycle as a bus commit to reg i: R returns the old value.
//   hw_we_i[i] in the same cycle as a bus commit to reg i: the bus write wins; wr_pulse_o[i] still pulses.
//   hw_we_i on other registers applies in the same cycle.
//   B and R are independent; a stalled b_ready never blocks reads, and a stalled r_ready never blocks writes.
// CONFIGURATION
//  AXI_REGFILE_WSTRB_EN defined: byte lane k of reg[idx] is written only when w_strb[k]=1.
//   A write with w_strb=0 still returns OKAY and still pulses wr_pulse_o.
//  Not defined: w_strb is ignored and every bus write replaces all 32 bits.
// STRUCTURE
//  Package axi_regfile_pkg holds:
//   resp_t enum (OKAY=2'b00, SLVERR=2'b10);
//   wr_state_t {W_COLLECT, W_RESP} and rd_state_t {R_IDLE, R_RESP};
//   function strb_merge(old, new, strb).
//  One sub-module, axi_regfile_addr_dec #(NUM_REGS, BASE_ADDR): addr -> idx, hit. Instantiated twice, once for AW and once for AR.
// TESTING
//  1. Reset, then AW+W same cycle to 0x08 with data 0xCAFE_F00D, b_ready=1 -> b_valid 2 cycles later with OKAY; regs_o[2]=0xCAFE_F00D; wr_pulse_o=16'h0004 for 1 cycle.
//  2. W first (0x1234_5678), then AW 0x0C three cycles later -> no B before AW; write lands after AW; OKAY; reg 3 updated.
//  3. AR 0x0C with r_ready held low for 5 cycles -> r_valid and r_data=0x1234_5678 stable for all 5 cycles; ar_ready=0 until R completes.
//  4. Write to 0x40 and read of 0x44 (NUM_REGS=16) -> both SLVERR; r_data=0; no register or wr_pulse_o change.
//  5. WSTRB_EN: reg1=0xFFFF_FFFF, write 0x0000_0000 with strb 4'b0101 -> reg1=0xFF00_FF00. Without the macro -> reg1=0x0.
//  6. hw_we_i[4] with 0xAAAA and bus write 0x5555 committing to reg 4 in the same cycle -> reg4=0x5555.
//     Assert rst_n=0 between AW and W of the next write -> no B; all regs=RESET_VAL.

Source files
------------

// File: rtl/axi_regfile_pkg.sv
// Shared types and helpers for the AXI-Lite register file slave.
//   resp_t      : AXI response codes used on B and R
//   wr_state_t  : write channel FSM states
//   rd_state_t  : read channel FSM states
//   wr_req_t    : latched AW/W payload
//   strb_merge  : byte-lane merge of new data over an old word
package axi_regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {W_COLLECT, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_RESP}    rd_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wr_req_t;

  function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_val,
                                                   input logic [DATA_W-1:0] new_val,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int k = 0; k < STRB_W; k++)
      if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
    return res;
  endfunction

endpackage

// File: rtl/axi_regfile_addr_dec.sv
// Byte address -> register index decoder.
//   addr : bus byte address (low two bits ignored)
//   idx  : register index, valid only when hit=1
//   hit  : address falls inside [BASE_ADDR, BASE_ADDR + 4*NUM_REGS)
module axi_regfile_addr_dec
  import axi_regfile_pkg::*;
#(
  parameter int                NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  localparam int               IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  idx,
  output logic              hit
);

  logic [ADDR_W-1:0] off;

  assign off = addr - BASE_ADDR;
  // The lower-bound test is needed because off wraps for addresses below base.
  assign hit = (addr >= BASE_ADDR) && (off < ADDR_W'(4 * NUM_REGS));
  assign idx = off[IDX_W+1:2];

endmodule

// File: rtl/axi_lite_regfile_slave.sv
// AXI-Lite subordinate register file.
// NUM_REGS 32-bit registers at BASE_ADDR + 4*i, with independent write
// (AW/W/B) and read (AR/R) channels plus a hardware-side update port.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   aw_*/w_*/b_*        : AXI-Lite write address, data, response
//   ar_*/r_*            : AXI-Lite read address, data
//   regs_o              : register contents, reg i at [32*i +: 32]
//   wr_pulse_o          : one-cycle pulse per register on a bus write commit
//   hw_we_i, hw_data_i  : per-register hardware write (bus write wins on clash)
// Build option: define AXI_REGFILE_WSTRB_EN to honour w_strb byte lanes;
// otherwise every bus write replaces the whole word.
module axi_lite_regfile_slave
  import axi_regfile_pkg::*;
#(
  parameter int                NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [DATA_W-1:0] RESET_VAL = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       aw_valid,
  output logic                       aw_ready,
  input  logic [ADDR_W-1:0]          aw_addr,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [DATA_W-1:0]          w_data,
  input  logic [STRB_W-1:0]          w_strb,
  output logic                       b_valid,
  input  logic                       b_ready,
  output logic [1:0]                 b_resp,
  input  logic                       ar_valid,
  output logic                       ar_ready,
  input  logic [ADDR_W-1:0]          ar_addr,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [DATA_W-1:0]          r_data,
  output logic [1:0]                 r_resp,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o,
  input  logic [NUM_REGS-1:0]        hw_we_i,
  input  logic [NUM_REGS*DATA_W-1:0] hw_data_i
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic                             aw_have, w_have;
  wr_req_t                          wr_req;
  resp_t                            b_resp_q, r_resp_q;
  logic [DATA_W-1:0]                r_data_q;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
  logic [NUM_REGS-1:0][DATA_W-1:0]  hw_data;
  logic [NUM_REGS-1:0]              wr_pulse;

  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              wr_hit, rd_hit;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic [DATA_W-1:0] wr_val;

  assign hw_data    = hw_data_i;
  assign regs_o     = regs;
  assign wr_pulse_o = wr_pulse;
  assign b_resp     = b_resp_q;
  assign r_resp     = r_resp_q;
  assign r_data     = r_data_q;

  assign aw_hs  = aw_valid && aw_ready;
  assign w_hs   = w_valid && w_ready;
  assign b_hs   = b_valid && b_ready;
  assign ar_hs  = ar_valid && ar_ready;
  assign r_hs   = r_valid && r_ready;
  // Commit from the latched flags, so a same-cycle AW+W pair commits one edge later.
  assign commit = (wr_state == W_COLLECT) && aw_have && w_have;

  axi_regfile_addr_dec #(.NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)) u_aw_dec (
    .addr (wr_req.addr),
    .idx  (wr_idx),
    .hit  (wr_hit)
  );

  axi_regfile_addr_dec #(.NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)) u_ar_dec (
    .addr (ar_addr),
    .idx  (rd_idx),
    .hit  (rd_hit)
  );

`ifdef AXI_REGFILE_WSTRB_EN
  assign wr_val = strb_merge(regs[wr_idx], wr_req.data, wr_req.strb);
`else
  logic unused_strb;
  assign unused_strb = ^wr_req.strb;
  assign wr_val      = wr_req.data;
`endif

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= W_COLLECT;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    wr_state_nxt = wr_state;
    unique case (wr_state)
      W_COLLECT: if (commit) wr_state_nxt = W_RESP;
      W_RESP:    if (b_hs)   wr_state_nxt = W_COLLECT;
      default:               wr_state_nxt = W_COLLECT;
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    unique case (rd_state)
      R_IDLE:  if (ar_hs) rd_state_nxt = R_RESP;
      R_RESP:  if (r_hs)  rd_state_nxt = R_IDLE;
      default:            rd_state_nxt = R_IDLE;
    endcase
  end

  // ---------------- state outputs ----------------
  // Readies depend only on registered state, never on the incoming valids.
  always_comb begin
    aw_ready = (wr_state == W_COLLECT) && !aw_have;
    w_ready  = (wr_state == W_COLLECT) && !w_have;
    b_valid  = (wr_state == W_RESP);
    ar_ready = (rd_state == R_IDLE);
    r_valid  = (rd_state == R_RESP);
  end

  // ---------------- write capture / response ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_have  <= 1'b0;
      w_have   <= 1'b0;
      wr_req   <= '0;
      b_resp_q <= OKAY;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        aw_have  <= 1'b0;
        w_have   <= 1'b0;
        b_resp_q <= wr_hit ? OKAY : SLVERR;
        if (wr_hit) wr_pulse[wr_idx] <= 1'b1;
      end else begin
        if (aw_hs) begin
          aw_have     <= 1'b1;
          wr_req.addr <= aw_addr;
        end
        if (w_hs) begin
          w_have      <= 1'b1;
          wr_req.data <= w_data;
          wr_req.strb <= w_strb;
        end
      end
    end
  end

  // ---------------- read response ----------------
  // Sampling regs here returns the pre-commit value on a same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q <= '0;
      r_resp_q <= OKAY;
    end else if (ar_hs) begin
      r_data_q <= rd_hit ? regs[rd_idx] : '0;
      r_resp_q <= rd_hit ? OKAY : SLVERR;
    end
  end

  // ---------------- register array ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && wr_hit && (wr_idx == IDX_W'(i))) regs[i] <= wr_val;
        else if (hw_we_i[i])                           regs[i] <= hw_data[i];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
module tb_axi_lite_regfile_slave;
  import axi_regfile_pkg::*;

  localparam int NR = 16;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic                  ar_valid, ar_ready, r_valid, r_ready;
  logic [31:0]           aw_addr, w_data, ar_addr, r_data;
  logic [3:0]            w_strb;
  logic [1:0]            b_resp, r_resp;
  logic [NR*32-1:0]      regs_o;
  logic [NR-1:0]         wr_pulse_o, hw_we_i;
  logic [NR-1:0][31:0]   hw_data;
  logic [NR-1:0][31:0]   exp_regs;

  logic [1:0] b_q[$];
  rsp_t       r_q[$];
  int         pulse_cnt[NR];
  int         checks = 0;
  int         failures = 0;
  int         p_snap;

  always #5 clk = ~clk;

  axi_lite_regfile_slave #(.NUM_REGS(NR), .BASE_ADDR(32'h0), .RESET_VAL(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o),
    .hw_we_i(hw_we_i), .hw_data_i(hw_data)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops expected B/R on each handshake, flags stray responses.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NR; i++) if (wr_pulse_o[i]) pulse_cnt[i]++;
      if (b_valid && b_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected resp=%0h", b_resp);
      end else if (b_valid && b_ready) begin
        chk("b_resp", b_resp, b_q.pop_front());
      end
      if (r_valid && r_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL r_unexpected data=%0h", r_data);
      end else if (r_valid && r_ready) begin
        rsp_t e;
        e = r_q.pop_front();
        chk("r_resp", r_resp, e.resp);
        chk("r_data", r_data, e.data);
      end
    end
  end

  task automatic xfer(input bit en_aw, input bit en_w, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    bit la, lw;
    aw_valid = en_aw; aw_addr = addr;
    w_valid  = en_w;  w_data  = data; w_strb = strb;
    while ((aw_valid || w_valid) && n < 20) begin
      @(negedge clk); la = aw_ready; lw = w_ready;
      @(posedge clk); #1;
      if (la) aw_valid = 1'b0;
      if (lw) w_valid  = 1'b0;
      n++;
    end
    checks++;
    if (aw_valid || w_valid) begin
      failures++;
      $display("FAIL xfer_timeout aw_valid=%0b w_valid=%0b", aw_valid, w_valid);
      aw_valid = 1'b0; w_valid = 1'b0;
    end
  endtask

  task automatic rd(input logic [31:0] addr);
    int n = 0;
    bit la;
    ar_valid = 1'b1; ar_addr = addr;
    while (ar_valid && n < 20) begin
      @(negedge clk); la = ar_ready;
      @(posedge clk); #1;
      if (la) ar_valid = 1'b0;
      n++;
    end
    checks++;
    if (ar_valid) begin
      failures++;
      $display("FAIL ar_timeout ar_valid=1 required=0");
      ar_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((b_q.size() != 0 || r_q.size() != 0) && n < 50) begin
      @(negedge clk); n++;
    end
    checks++;
    if (b_q.size() != 0 || r_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout b_left=%0d r_left=%0d", b_q.size(), r_q.size());
    end
  endtask

  function automatic int pulse_total();
    int s = 0;
    for (int i = 0; i < NR; i++) s += pulse_cnt[i];
    return s;
  endfunction

  initial begin
    rst_n = 1'b0;
    aw_valid = 0; w_valid = 0; ar_valid = 0; b_ready = 1; r_ready = 1;
    aw_addr = 0; w_data = 0; w_strb = 0; ar_addr = 0;
    hw_we_i = '0; hw_data = '0; exp_regs = '0;
    for (int i = 0; i < NR; i++) pulse_cnt[i] = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_regs", regs_o, exp_regs);
    chk("rst_bvalid", b_valid, 0);
    chk("rst_rvalid", r_valid, 0);
    chk("rst_resp", {b_resp, r_resp}, 0);
    chk("rst_rdata", r_data, 0);
    chk("rst_pulse", wr_pulse_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_readies", {aw_ready, w_ready, ar_ready}, 3'b111);
    @(posedge clk); #1;

    // 1: AW+W same cycle to reg 2
    b_q.push_back(OKAY);
    xfer(1, 1, 32'h08, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    chk("t1_b_not_yet", b_valid, 0);
    @(negedge clk);
    exp_regs[2] = 32'hCAFE_F00D;
    chk("t1_b_valid", b_valid, 1);
    chk("t1_regs", regs_o, exp_regs);
    chk("t1_pulse", wr_pulse_o, 16'h0004);
    @(negedge clk);
    chk("t1_pulse_clear", wr_pulse_o, 0);
    wait_drain();

    // 2: W first, AW three cycles later
    @(posedge clk); #1;
    b_q.push_back(OKAY);
    xfer(0, 1, 32'h0, 32'h1234_5678, 4'hF);
    repeat (3) begin
      @(negedge clk);
      chk("t2_no_early_b", {b_valid, w_ready, regs_o[3*32 +: 32]}, {1'b0, 1'b0, 32'h0});
    end
    @(posedge clk); #1;
    xfer(1, 0, 32'h0C, 32'h0, 4'h0);
    wait_drain();
    exp_regs[3] = 32'h1234_5678;
    chk("t2_regs", regs_o, exp_regs);

    // 3: read with r_ready held low for 5 cycles
    r_ready = 1'b0;
    @(posedge clk); #1;
    r_q.push_back('{OKAY, 32'h1234_5678});
    rd(32'h0C);
    repeat (5) begin
      @(negedge clk);
      chk("t3_hold", {r_valid, ar_ready, r_data}, {1'b1, 1'b0, 32'h1234_5678});
    end
    r_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    chk("t3_ar_ready_back", ar_ready, 1);

    // 4: out-of-range write and read
    p_snap = pulse_total();
    @(posedge clk); #1;
    b_q.push_back(SLVERR);
    xfer(1, 1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    r_q.push_back('{SLVERR, 32'h0});
    rd(32'h44);
    wait_drain();
    chk("t4_regs", regs_o, exp_regs);
    chk("t4_no_pulse", pulse_total(), p_snap);

    // 5: byte strobes on reg 1 (preloaded via hw port)
    @(posedge clk); #1;
    hw_we_i = 16'h0002; hw_data[1] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    hw_we_i = '0;
    exp_regs[1] = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("t5_hw_load", regs_o, exp_regs);
    p_snap = pulse_cnt[1];
    @(posedge clk); #1;
    b_q.push_back(OKAY);
    xfer(1, 1, 32'h04, 32'h0000_0000, 4'b0101);
    wait_drain();
`ifdef AXI_REGFILE_WSTRB_EN
    exp_regs[1] = 32'hFF00_FF00;
`else
    exp_regs[1] = 32'h0000_0000;
`endif
    chk("t5_strb", regs_o, exp_regs);
    chk("t5_pulse", pulse_cnt[1], p_snap + 1);

    // 6: hw write vs bus commit on reg 4, hw on reg 5, AR to reg 4 on commit edge
    p_snap = pulse_cnt[4];
    @(posedge clk); #1;
    b_q.push_back(OKAY);
    xfer(1, 1, 32'h10, 32'h0000_5555, 4'hF);
    hw_we_i = 16'h0030; hw_data[4] = 32'h0000_AAAA; hw_data[5] = 32'h0000_BEEF;
    ar_valid = 1'b1; ar_addr = 32'h10;
    r_q.push_back('{OKAY, 32'h0});
    @(posedge clk); #1;
    hw_we_i = '0; ar_valid = 1'b0;
    wait_drain();
    exp_regs[4] = 32'h0000_5555;
    exp_regs[5] = 32'h0000_BEEF;
    chk("t6_regs", regs_o, exp_regs);
    chk("t6_pulse", pulse_cnt[4], p_snap + 1);

    // Reset between AW and W: pending AW dropped, no B
    @(posedge clk); #1;
    xfer(1, 0, 32'h14, 32'h0, 4'h0);
    @(negedge clk); rst_n = 1'b0;
    exp_regs = '0;
    @(negedge clk);
    chk("rst2_state", {regs_o, b_valid, wr_pulse_o}, {exp_regs, 1'b0, 16'h0});
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(0, 1, 32'h0, 32'h0000_0099, 4'hF);
    repeat (4) begin
      @(negedge clk);
      chk("rst2_no_b", {b_valid, regs_o}, {1'b0, exp_regs});
    end
    @(posedge clk); #1;
    b_q.push_back(OKAY);
    xfer(1, 0, 32'h18, 32'h0, 4'h0);
    wait_drain();
    exp_regs[6] = 32'h0000_0099;
    chk("rst2_regs", regs_o, exp_regs);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
